// File: rtl/controller_data_ram_port2_arbiter_pkg.sv
// Shared definitions for the controller data RAM port-2 arbiter.
//   RAM_ADDR_W / RAM_DATA_W / RAM_BE_W : geometry of the 4096x32 data RAM
//   req_id_t                           : encoded master index, sized for the
//                                        largest supported master count (8)
//   next_id()                          : round-robin successor, wrapping at num_req
package controller_ram_pkg;

    localparam int RAM_ADDR_W = 12;
    localparam int RAM_DATA_W = 32;
    localparam int RAM_BE_W   = 4;
    localparam int MAX_REQ    = 8;
    localparam int REQ_ID_W   = $clog2(MAX_REQ);

    typedef logic [REQ_ID_W-1:0] req_id_t;

    // Successor of id in a ring of num_req masters (num_req-1 wraps to 0).
    function automatic req_id_t next_id(input req_id_t id, input int num_req);
        req_id_t nxt;
        if (int'(id) >= (num_req - 1)) begin
            nxt = req_id_t'(0);
        end else begin
            nxt = id + req_id_t'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/controller_data_ram_port2_arbiter_chk.sv
// Protocol checker for the port-2 arbiter; bound alongside the arbiter in simulation.
//   clk, reset         : arbiter clock and synchronous reset
//   m_read, m_write    : master request lines
//   m_waitrequest      : arbiter stall outputs (at most one low)
//   m_readdatavalid    : arbiter response strobes (at most one high)
module controller_data_ram_port2_arbiter_chk #(
    parameter int NUM_REQ = 4
) (
    input logic               clk,
    input logic               reset,
    input logic [NUM_REQ-1:0] m_read,
    input logic [NUM_REQ-1:0] m_write,
    input logic [NUM_REQ-1:0] m_waitrequest,
    input logic [NUM_REQ-1:0] m_readdatavalid
);

    // Read and write together on one master is resolved as a write, but flagged.
    a_no_rd_wr: assert property (@(posedge clk) disable iff (reset)
        (m_read & m_write) == {NUM_REQ{1'b0}})
        else $error("arbiter: a master drives read and write together");

    a_one_grant: assert property (@(posedge clk) disable iff (reset)
        $onehot0(~m_waitrequest))
        else $error("arbiter: more than one master accepted in a cycle");

    a_one_resp: assert property (@(posedge clk) disable iff (reset)
        $onehot0(m_readdatavalid))
        else $error("arbiter: more than one response strobe in a cycle");

endmodule

// File: rtl/controller_data_ram_port2_arbiter_rr_pick.sv
// Rotating-priority picker (purely combinational).
//   req    in  NUM_REQ  eligible request vector
//   rr_ptr in  req_id_t index searched first; search wraps NUM_REQ-1 -> 0
//   grant  out NUM_REQ  one-hot winner (all zero when nothing requests)
//   winner out req_id_t encoded winner (0 when nothing requests)
//   any    out 1        at least one request present
module controller_rr_pick
    import controller_ram_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  req_id_t            rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output req_id_t            winner,
    output logic               any
);

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    // Walk the ring starting at rr_ptr; the first hit wins and later hits are masked.
    always_comb begin
        int                 idx;
        logic [NUM_REQ-1:0] sel;
        logic               hit;
        grant  = {NUM_REQ{1'b0}};
        winner = req_id_t'(0);
        any    = 1'b0;
        idx    = 0;
        sel    = {NUM_REQ{1'b0}};
        hit    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx    = int'(rr_ptr) + k;
            idx    = (idx >= NUM_REQ) ? (idx - NUM_REQ) : idx;
            sel    = ONE_HOT0 << idx;
            hit    = !any && (|(req & sel));
            grant  = hit ? sel : grant;
            winner = hit ? req_id_t'(idx) : winner;
            any    = any | hit;
        end
    end

endmodule

// File: rtl/controller_data_ram_port2_arbiter.sv
// Port-2 arbiter for the controller's 4096x32 dual-port data RAM.
// NUM_REQ Avalon-MM masters share RAM slave s2 with round-robin grant, one
// access per cycle, fixed 1-cycle read latency and an optional per-master
// lock that holds the grant across a read-modify-write.
//   clk, reset                  : clock, synchronous active-high reset
//   reset_req                   : RAM frozen while high; no new accesses
//   m_address/m_byteenable/
//   m_read/m_write/m_writedata/
//   m_lock                      : packed per-master request fields
//   m_waitrequest               : low for the single accepted master
//   m_readdatavalid/m_readdata  : one-hot response strobe, broadcast data
//   ram_*2                      : RAM s2 slave interface
module controller_data_ram_port2_arbiter
    import controller_ram_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = RAM_ADDR_W,
    parameter int DATA_W  = RAM_DATA_W,
    parameter int BE_W    = RAM_BE_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    reset_req,
    input  logic [NUM_REQ*ADDR_W-1:0] m_address,
    input  logic [NUM_REQ*BE_W-1:0]   m_byteenable,
    input  logic [NUM_REQ-1:0]        m_read,
    input  logic [NUM_REQ-1:0]        m_write,
    input  logic [NUM_REQ*DATA_W-1:0] m_writedata,
    input  logic [NUM_REQ-1:0]        m_lock,
    output logic [NUM_REQ-1:0]        m_waitrequest,
    output logic [NUM_REQ-1:0]        m_readdatavalid,
    output logic [DATA_W-1:0]         m_readdata,
    output logic [ADDR_W-1:0]         ram_address2,
    output logic [BE_W-1:0]           ram_byteenable2,
    output logic                      ram_chipselect2,
    output logic                      ram_write2,
    output logic [DATA_W-1:0]         ram_writedata2,
    output logic                      ram_clken2,
    input  logic [DATA_W-1:0]         ram_readdata2
);

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [NUM_REQ-1:0] req_s;
    logic [NUM_REQ-1:0] owner_mask_s;
    logic [NUM_REQ-1:0] eligible_s;
    logic [NUM_REQ-1:0] pick_grant_s;
    req_id_t            winner_s;
    logic               pick_any_s;
    logic               accept_s;
    logic               wr_sel_s;
    logic               release_s;

    req_id_t            rr_ptr_r;
    req_id_t            lock_owner_r;
    logic               lock_valid_r;
    logic               rd_pending_r;
    req_id_t            rd_id_r;

    // Request vector and lock filtering: a held lock leaves only the owner eligible.
    always_comb begin
        req_s        = m_read | m_write;
        owner_mask_s = ONE_HOT0 << lock_owner_r;
        if (lock_valid_r) begin
            eligible_s = req_s & owner_mask_s;
        end else begin
            eligible_s = req_s;
        end
    end

    controller_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req    (eligible_s),
        .rr_ptr (rr_ptr_r),
        .grant  (pick_grant_s),
        .winner (winner_s),
        .any    (pick_any_s)
    );

    // Accept decision, RAM request mux and per-master stall outputs.
    always_comb begin
        accept_s        = pick_any_s & ~reset_req & ~reset;
        wr_sel_s        = |(pick_grant_s & m_write);
        ram_address2    = {ADDR_W{1'b0}};
        ram_byteenable2 = {BE_W{1'b0}};
        ram_writedata2  = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            ram_address2    = ram_address2 |
                              ({ADDR_W{pick_grant_s[i]}} & m_address[i*ADDR_W +: ADDR_W]);
            ram_byteenable2 = ram_byteenable2 |
                              ({BE_W{pick_grant_s[i]}} & m_byteenable[i*BE_W +: BE_W]);
            ram_writedata2  = ram_writedata2 |
                              ({DATA_W{pick_grant_s[i]}} & m_writedata[i*DATA_W +: DATA_W]);
        end
        ram_chipselect2 = accept_s;
        ram_write2      = accept_s & wr_sel_s;
        ram_clken2      = 1'b1;
        if (accept_s) begin
            m_waitrequest = ~pick_grant_s;
        end else begin
            m_waitrequest = {NUM_REQ{1'b1}};
        end
        // An idle owner that has dropped its lock frees the grant; frozen RAM holds it.
        release_s = lock_valid_r & ~reset_req &
                    ~(|(req_s & owner_mask_s)) & ~(|(m_lock & owner_mask_s));
    end

    // Response demux: the RAM output is unregistered, so data passes straight through.
    always_comb begin
        m_readdata = ram_readdata2;
        if (rd_pending_r && !reset) begin
            m_readdatavalid = ONE_HOT0 << rd_id_r;
        end else begin
            m_readdatavalid = {NUM_REQ{1'b0}};
        end
    end

    // Round-robin pointer, lock ownership and read-pending tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_r     <= req_id_t'(0);
            lock_owner_r <= req_id_t'(0);
            lock_valid_r <= 1'b0;
            rd_pending_r <= 1'b0;
            rd_id_r      <= req_id_t'(0);
        end else begin
            rd_pending_r <= accept_s & ~wr_sel_s;
            if (accept_s) begin
                rr_ptr_r     <= next_id(winner_s, NUM_REQ);
                lock_owner_r <= winner_s;
                lock_valid_r <= |(m_lock & pick_grant_s);
                rd_id_r      <= winner_s;
            end else if (release_s) begin
                lock_valid_r <= 1'b0;
            end else begin
                lock_valid_r <= lock_valid_r;
            end
        end
    end

endmodule

// File: tb/tb_controller_data_ram_port2_arbiter.sv
// Scoreboard bench for controller_data_ram_port2_arbiter: the driver pushes the
// expected RAM accesses and read responses, a negedge monitor pops and compares
// them whenever the DUT presents an access or a response strobe.
module tb_controller_data_ram_port2_arbiter;
    import controller_ram_pkg::*;

    localparam int NR = 4;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int BW = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              reset_req;
    logic [NR*AW-1:0]  m_address;
    logic [NR*BW-1:0]  m_byteenable;
    logic [NR-1:0]     m_read;
    logic [NR-1:0]     m_write;
    logic [NR*DW-1:0]  m_writedata;
    logic [NR-1:0]     m_lock;
    logic [NR-1:0]     m_waitrequest;
    logic [NR-1:0]     m_readdatavalid;
    logic [DW-1:0]     m_readdata;
    logic [AW-1:0]     ram_address2;
    logic [BW-1:0]     ram_byteenable2;
    logic              ram_chipselect2;
    logic              ram_write2;
    logic [DW-1:0]     ram_writedata2;
    logic              ram_clken2;
    logic [DW-1:0]     ram_readdata2;

    always #5 clk = ~clk;

    controller_data_ram_port2_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .reset_req       (reset_req),
        .m_address       (m_address),
        .m_byteenable    (m_byteenable),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_lock          (m_lock),
        .m_waitrequest   (m_waitrequest),
        .m_readdatavalid (m_readdatavalid),
        .m_readdata      (m_readdata),
        .ram_address2    (ram_address2),
        .ram_byteenable2 (ram_byteenable2),
        .ram_chipselect2 (ram_chipselect2),
        .ram_write2      (ram_write2),
        .ram_writedata2  (ram_writedata2),
        .ram_clken2      (ram_clken2),
        .ram_readdata2   (ram_readdata2)
    );

    controller_data_ram_port2_arbiter_chk #(.NUM_REQ(NR)) u_chk (
        .clk             (clk),
        .reset           (reset),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_waitrequest   (m_waitrequest),
        .m_readdatavalid (m_readdatavalid)
    );

    // RAM s2 model: byte-masked write, registered read, backdoor preload port.
    logic [DW-1:0] mem [0:4095];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (ram_chipselect2 && ram_clken2) begin
            if (ram_write2) begin
                for (int b = 0; b < BW; b++) begin
                    if (ram_byteenable2[b]) mem[ram_address2][b*8 +: 8] <= ram_writedata2[b*8 +: 8];
                end
            end else begin
                ram_readdata2 <= mem[ram_address2];
            end
        end
    end

    typedef struct {
        int            id;
        logic          wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] be;
        logic [DW-1:0] data;
    } acc_t;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } rd_t;

    acc_t acc_q[$];
    rd_t  rd_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    // Monitor: compare every presented access and every response against the queues.
    always @(negedge clk) begin
        acc_t          e;
        rd_t           r;
        logic [NR-1:0] ew;
        logic [NR-1:0] ev;
        if (ram_chipselect2 === 1'b1) begin
            if (acc_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_access: addr 0x%0h, no access expected", ram_address2);
            end else begin
                e  = acc_q.pop_front();
                ew = ~(4'b0001 << e.id);
                check("acc_waitrequest", {60'd0, m_waitrequest}, {60'd0, ew});
                check("acc_address", {52'd0, ram_address2}, {52'd0, e.addr});
                check("acc_write", {63'd0, ram_write2}, {63'd0, e.wr});
                if (e.wr) begin
                    check("acc_byteenable", {60'd0, ram_byteenable2}, {60'd0, e.be});
                    check("acc_writedata", {32'd0, ram_writedata2}, {32'd0, e.data});
                end
            end
        end
        if (m_readdatavalid !== 4'b0000) begin
            if (rd_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_response: valid 0x%0h, no response expected", m_readdatavalid);
            end else begin
                r  = rd_q.pop_front();
                ev = 4'b0001 << r.id;
                check("rsp_valid", {60'd0, m_readdatavalid}, {60'd0, ev});
                check("rsp_data", {32'd0, m_readdata}, {32'd0, r.data});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m_read  = 4'b0000;
        m_write = 4'b0000;
        m_lock  = 4'b0000;
    endtask

    task automatic set_m(input int i, input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [BW-1:0] be, input logic [DW-1:0] d, input logic lk);
        m_read[i]               = rd;
        m_write[i]              = wr;
        m_address[i*AW +: AW]   = a;
        m_byteenable[i*BW +: BW] = be;
        m_writedata[i*DW +: DW] = d;
        m_lock[i]               = lk;
    endtask

    task automatic push_acc(input int id, input logic wr, input logic [AW-1:0] a,
                            input logic [BW-1:0] be, input logic [DW-1:0] d);
        acc_t e;
        e.id = id; e.wr = wr; e.addr = a; e.be = be; e.data = d;
        acc_q.push_back(e);
    endtask

    task automatic push_rd(input int id, input logic [DW-1:0] d);
        rd_t r;
        r.id = id; r.data = d;
        rd_q.push_back(r);
    endtask

    logic [AW-1:0] pa [5];
    logic [DW-1:0] pd [5];
    logic [DW-1:0] wdat [4];

    initial begin
        pa   = '{12'h005, 12'h100, 12'h0FF, 12'h200, 12'h300};
        pd   = '{32'hDEADBEEF, 32'h0BAD0100, 32'hAAAAAAAA, 32'h22220200, 32'h33330300};
        wdat = '{32'hC0DE0000, 32'hC0DE1111, 32'hC0DE2222, 32'hC0DE3333};

        reset        = 1'b1;
        reset_req    = 1'b0;
        pl_en        = 1'b0;
        pl_addr      = 12'h000;
        pl_data      = 32'h0;
        m_address    = '0;
        m_byteenable = '0;
        m_writedata  = '0;
        idle();
        // Reset with every master requesting: all stalled, no response strobes.
        for (int i = 0; i < NR; i++) set_m(i, 1'b1, 1'b0, 12'h000, 4'hF, 32'h0, 1'b0);
        for (int p = 0; p < 5; p++) begin
            pl_en = 1'b1; pl_addr = pa[p]; pl_data = pd[p];
            @(negedge clk);
            check("reset_waitrequest", {60'd0, m_waitrequest}, 64'hF);
            check("reset_readdatavalid", {60'd0, m_readdatavalid}, 64'h0);
            step();
        end
        pl_en = 1'b0;
        idle();
        reset = 1'b0;

        // 1: lone read by master 2, response exactly one cycle later.
        set_m(2, 1'b1, 1'b0, 12'h005, 4'hF, 32'h0, 1'b0);
        push_acc(2, 1'b0, 12'h005, 4'hF, 32'h0);
        push_rd(2, 32'hDEADBEEF);
        step();
        idle();
        @(negedge clk);
        check("t1_latency", {60'd0, m_readdatavalid}, 64'h4);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;

        // 2: all four write continuously; grants rotate 0,1,2,3,0,1,2,3.
        for (int i = 0; i < NR; i++) set_m(i, 1'b0, 1'b1, 12'h010 + 12'(i), 4'hF, wdat[i], 1'b0);
        for (int c = 0; c < 8; c++) push_acc(c % 4, 1'b1, 12'h010 + 12'(c % 4), 4'hF, wdat[c % 4]);
        repeat (8) step();
        idle();
        for (int i = 0; i < NR; i++) begin
            set_m(0, 1'b1, 1'b0, 12'h010 + 12'(i), 4'hF, 32'h0, 1'b0);
            push_acc(0, 1'b0, 12'h010 + 12'(i), 4'hF, 32'h0);
            push_rd(0, wdat[i]);
            step();
        end
        idle();
        step();

        // 3: master 1 locked read-modify-write while 0 and 3 wait (rr_ptr = 1).
        set_m(0, 1'b1, 1'b0, 12'h200, 4'hF, 32'h0, 1'b0);
        set_m(3, 1'b1, 1'b0, 12'h300, 4'hF, 32'h0, 1'b0);
        set_m(1, 1'b1, 1'b0, 12'h100, 4'hF, 32'h0, 1'b1);
        push_acc(1, 1'b0, 12'h100, 4'hF, 32'h0);
        push_rd(1, 32'h0BAD0100);
        step();
        set_m(1, 1'b0, 1'b1, 12'h100, 4'hF, 32'h11112222, 1'b0);
        push_acc(1, 1'b1, 12'h100, 4'hF, 32'h11112222);
        step();
        set_m(1, 1'b0, 1'b0, 12'h000, 4'h0, 32'h0, 1'b0);
        push_acc(3, 1'b0, 12'h300, 4'hF, 32'h0);
        push_rd(3, 32'h33330300);
        step();
        set_m(3, 1'b0, 1'b0, 12'h000, 4'h0, 32'h0, 1'b0);
        push_acc(0, 1'b0, 12'h200, 4'hF, 32'h0);
        push_rd(0, 32'h22220200);
        step();
        idle();
        set_m(1, 1'b1, 1'b0, 12'h100, 4'hF, 32'h0, 1'b0);
        push_acc(1, 1'b0, 12'h100, 4'hF, 32'h0);
        push_rd(1, 32'h11112222);
        step();
        idle();
        step();

        // 4: read by 2 (rr_ptr -> 3), then reset_req for 3 cycles with all requesting.
        set_m(2, 1'b1, 1'b0, 12'h012, 4'hF, 32'h0, 1'b0);
        push_acc(2, 1'b0, 12'h012, 4'hF, 32'h0);
        push_rd(2, wdat[2]);
        step();
        reset_req = 1'b1;
        for (int i = 0; i < NR; i++) set_m(i, 1'b1, 1'b0, 12'h010 + 12'(i), 4'hF, 32'h0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("hold_chipselect", {63'd0, ram_chipselect2}, 64'h0);
            check("hold_waitrequest", {60'd0, m_waitrequest}, 64'hF);
            if (c == 0) check("hold_pending_rsp", {60'd0, m_readdatavalid}, 64'h4);
            step();
        end
        reset_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            push_acc((c + 3) % 4, 1'b0, 12'h010 + 12'((c + 3) % 4), 4'hF, 32'h0);
            push_rd((c + 3) % 4, wdat[(c + 3) % 4]);
        end
        repeat (4) step();
        idle();
        step();

        // 5: partial byte write then read back.
        set_m(0, 1'b0, 1'b1, 12'h0FF, 4'b0011, 32'h12345678, 1'b0);
        push_acc(0, 1'b1, 12'h0FF, 4'b0011, 32'h12345678);
        step();
        set_m(0, 1'b1, 1'b0, 12'h0FF, 4'hF, 32'h0, 1'b0);
        push_acc(0, 1'b0, 12'h0FF, 4'hF, 32'h0);
        push_rd(0, 32'hAAAA5678);
        step();
        idle();
        step();
        step();

        // 6: reset right after an accepted read drops the response and clears rr_ptr.
        set_m(1, 1'b1, 1'b0, 12'h010, 4'hF, 32'h0, 1'b0);
        push_acc(1, 1'b0, 12'h010, 4'hF, 32'h0);
        step();
        idle();
        reset = 1'b1;
        @(negedge clk);
        check("t6_dropped_rsp", {60'd0, m_readdatavalid}, 64'h0);
        step();
        reset = 1'b0;
        for (int i = 0; i < NR; i++) set_m(i, 1'b1, 1'b0, 12'h010 + 12'(i), 4'hF, 32'h0, 1'b0);
        push_acc(0, 1'b0, 12'h010, 4'hF, 32'h0);
        push_rd(0, wdat[0]);
        step();
        idle();
        repeat (3) step();

        check("acc_queue_drained", 64'(acc_q.size()), 64'h0);
        check("rsp_queue_drained", 64'(rd_q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
